// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding, burst limits
// and default widths.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_BURST  = 16;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN_W  = 5;

  function automatic logic len_ok(input int unsigned len);
    return (len != 0) && (len <= MAX_BURST);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_buf2.sv
// Two-entry first-in first-out output buffer; head entry drives dout_o,
// and a push and a pop may happen in the same cycle.
module skid_buf2
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              valid_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              pop_ok;

  assign pop_ok = pop_i && (occ_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_i, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) head_d = din_i;
        else               tail_d = din_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop: the incoming word lands behind whatever
        // remains after the head leaves.
        if (occ_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign dout_o  = head_q;
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a fixed-length burst from a synchronous FIFO and streams it out
// through a two-entry buffer with valid/ready handshaking.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_re,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  delivered_q, delivered_d;
  logic              inflight_q;
  logic [1:0]        occ;
  logic [2:0]        slots;
  logic              xfer;

  skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .rst     (reset),
    .push_i  (inflight_q),
    .pop_i   (xfer),
    .din_i   (fifo_data),
    .dout_o  (m_data),
    .valid_o (m_valid),
    .occ_o   (occ)
  );

  assign xfer = m_valid && m_ready;

  // Occupancy net of this cycle's transfer, so a read can be issued while the
  // head drains; that is what sustains one beat per cycle.
  assign slots = 3'(occ) + 3'(inflight_q) - 3'(xfer);

  assign fifo_re = (state_q == ST_READ) && !fifo_empty &&
                   (issued_q < len_q) && (slots < 3'd2);

  assign m_last = m_valid && (delivered_q == (len_q - LEN_W'(1)));
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok(32'(burst_len))) begin
          len_d       = burst_len;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (fifo_re) issued_d = issued_q + LEN_W'(1);
        if (xfer && (delivered_q < len_q)) delivered_d = delivered_q + LEN_W'(1);
        if (xfer && m_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= fifo_re;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural sync FIFO and a
// stream monitor.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_re;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          done;

  logic          tb_we = 1'b0;
  logic [7:0]    tb_wd = '0;
  logic          tb_flush = 1'b0;
  logic          mon_clr = 1'b0;
  logic [7:0]    mem [0:255];
  int            wptr = 0;
  int            rptr = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0, re_cnt = 0, bad_re = 0, done_cnt = 0, done_cyc = 0;
  int out_cnt = 0, max_out = 0;
  logic [7:0] rx_data[$];
  logic       rx_last[$];
  int         rx_cyc[$];

  fifo_burst_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wptr == rptr);

  always @(posedge clk) begin
    if (tb_flush) rptr <= wptr;
    else if (fifo_re && !fifo_empty) begin
      fifo_data <= mem[rptr[7:0]];
      rptr      <= rptr + 1;
    end
    if (tb_we) begin
      mem[wptr[7:0]] <= tb_wd;
      wptr           <= wptr + 1;
    end
  end

  always @(negedge clk) begin
    int o;
    cyc <= cyc + 1;
    if (reset) begin
      out_cnt <= 0;
    end else begin
      if (fifo_re) re_cnt <= re_cnt + 1;
      if (fifo_re && fifo_empty) bad_re <= bad_re + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (m_valid && m_ready) begin
        rx_data.push_back(m_data);
        rx_last.push_back(m_last);
        rx_cyc.push_back(cyc);
      end
      o = out_cnt + (fifo_re ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      out_cnt <= o;
      if (mon_clr) max_out <= 0;
      else if (o > max_out) max_out <= o;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      tb_we = 1'b1;
      tb_wd = base + 8'(i);
      tick(1);
    end
    tb_we = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    start     = 1'b1;
    burst_len = LW'(len);
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (done_cnt > prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (rx_data.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (fifo_re !== 1'b0) begin failures++; $display("FAIL rst_fifo_re got=%b exp=0", fifo_re); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data got=%h exp=00", m_data); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int base, re0, d0, errs;
    bit ok;
    push_bytes(8'h11, 4);
    base = rx_data.size(); re0 = re_cnt; d0 = done_cnt;
    m_ready = 1'b1;
    pulse_start(4);
    wait_done(d0, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    checks++; if (rx_data.size() - base != 4) begin failures++; $display("FAIL basic_beats got=%0d exp=4", rx_data.size() - base); end
    if (rx_data.size() - base >= 4) begin
      errs = 0;
      for (int i = 0; i < 4; i++)
        if (rx_data[base+i] !== 8'h11 + 8'(i) || rx_last[base+i] !== (i == 3)) errs++;
      checks++; if (errs != 0) begin failures++; $display("FAIL basic_data_last got_errs=%0d exp=0", errs); end
      checks++; if (rx_cyc[base+3] - rx_cyc[base] != 3) begin failures++; $display("FAIL basic_consecutive got_span=%0d exp=3", rx_cyc[base+3] - rx_cyc[base]); end
      checks++; if (done_cyc != rx_cyc[base+3] + 1) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, rx_cyc[base+3] + 1); end
    end
    checks++; if (re_cnt - re0 != 4) begin failures++; $display("FAIL basic_reads got=%0d exp=4", re_cnt - re0); end
    tick(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int base, d0, errs;
    bit ok;
    logic [7:0] held;
    push_bytes(8'h21, 6);
    mon_clr = 1'b1; tick(1); mon_clr = 1'b0;
    base = rx_data.size(); d0 = done_cnt;
    m_ready = 1'b1;
    pulse_start(6);
    wait_rx(base + 2, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_rx_timeout got=0 exp=1"); end
    m_ready = 1'b0;
    held = m_data;
    checks++; if (held !== 8'h23 || m_valid !== 1'b1) begin failures++; $display("FAIL bp_head got=%h/%b exp=23/1", held, m_valid); end
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (m_valid !== 1'b1 || m_data !== held) errs++;
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL bp_stable got_errs=%0d exp=0", errs); end
    m_ready = 1'b1;
    wait_done(d0, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    errs = 0;
    if (rx_data.size() - base != 6) errs++;
    else for (int i = 0; i < 6; i++) if (rx_data[base+i] !== 8'h21 + 8'(i)) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL bp_data got_errs=%0d exp=0", errs); end
    checks++; if (max_out > 2) begin failures++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
    tick(1);
  endtask

  task automatic test_empty_stall();
    int base, re0, d0, bad0;
    bit ok;
    bad0 = bad_re;
    push_bytes(8'h31, 2);
    base = rx_data.size(); re0 = re_cnt; d0 = done_cnt;
    pulse_start(3);
    tick(6);
    checks++; if (re_cnt - re0 != 2) begin failures++; $display("FAIL stall_reads got=%0d exp=2", re_cnt - re0); end
    checks++; if (rx_data.size() - base != 2) begin failures++; $display("FAIL stall_beats got=%0d exp=2", rx_data.size() - base); end
    checks++; if (fifo_re !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL stall_state got=re%b/busy%b exp=re0/busy1", fifo_re, busy); end
    push_bytes(8'hA5, 1);
    wait_done(d0, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_done_timeout got=0 exp=1"); end
    if (rx_data.size() - base == 3) begin
      checks++; if (rx_data[base+2] !== 8'hA5 || rx_last[base+2] !== 1'b1) begin failures++; $display("FAIL stall_last got=%h/%b exp=a5/1", rx_data[base+2], rx_last[base+2]); end
    end else begin
      checks++; failures++; $display("FAIL stall_count got=%0d exp=3", rx_data.size() - base);
    end
    checks++; if (bad_re != bad0) begin failures++; $display("FAIL stall_empty_read got=%0d exp=%0d", bad_re, bad0); end
    tick(1);
  endtask

  task automatic test_ignored();
    int base, re0, d0;
    bit ok;
    re0 = re_cnt; d0 = done_cnt;
    pulse_start(0);
    tick(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_len0_busy got=%b exp=0", busy); end
    pulse_start(17);
    tick(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_len17_busy got=%b exp=0", busy); end
    checks++; if (re_cnt != re0 || done_cnt != d0) begin failures++; $display("FAIL ign_activity got=re%0d/done%0d exp=0/0", re_cnt - re0, done_cnt - d0); end
    base = rx_data.size();
    pulse_start(2);
    tick(2);
    checks++; if (busy !== 1'b1 || fifo_re !== 1'b0) begin failures++; $display("FAIL ign_wait_state got=busy%b/re%b exp=1/0", busy, fifo_re); end
    pulse_start(5);
    push_bytes(8'h41, 2);
    wait_done(d0, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ign_done_timeout got=0 exp=1"); end
    tick(3);
    checks++; if (rx_data.size() - base != 2 || re_cnt - re0 != 2) begin failures++; $display("FAIL ign_len_kept got=beats%0d/reads%0d exp=2/2", rx_data.size() - base, re_cnt - re0); end
    if (rx_data.size() - base >= 2) begin
      checks++; if (rx_last[base] !== 1'b0 || rx_last[base+1] !== 1'b1 || rx_data[base+1] !== 8'h42) begin failures++; $display("FAIL ign_last got=%b%b/%h exp=01/42", rx_last[base], rx_last[base+1], rx_data[base+1]); end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int base, d0;
    bit ok;
    logic [7:0] exp_next;
    push_bytes(8'h51, 8);
    base = rx_data.size();
    pulse_start(8);
    wait_rx(base + 2, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_rx_timeout got=0 exp=1"); end
    reset = 1'b1;
    #1;
    checks++; if ({fifo_re, m_valid, m_last, busy, done} !== 5'b0 || m_data !== 8'h00) begin
      failures++; $display("FAIL rmid_outputs got=re%b v%b l%b b%b d%b data%h exp=all0", fifo_re, m_valid, m_last, busy, done, m_data);
    end
    exp_next = mem[rptr[7:0]];
    @(posedge clk); #1;
    reset = 1'b0;
    base = rx_data.size(); d0 = done_cnt;
    pulse_start(1);
    wait_done(d0, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_done_timeout got=0 exp=1"); end
    if (rx_data.size() - base == 1) begin
      checks++; if (rx_data[base] !== exp_next || rx_last[base] !== 1'b1) begin failures++; $display("FAIL rmid_next_byte got=%h/%b exp=%h/1", rx_data[base], rx_last[base], exp_next); end
    end else begin
      checks++; failures++; $display("FAIL rmid_count got=%0d exp=1", rx_data.size() - base);
    end
    tb_flush = 1'b1; tick(1); tb_flush = 1'b0;
    tick(1);
  endtask

  task automatic test_full16();
    int base, re0, d0, errs;
    bit ok;
    push_bytes(8'h60, 16);
    base = rx_data.size(); re0 = re_cnt; d0 = done_cnt;
    pulse_start(16);
    wait_done(d0, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_done_timeout got=0 exp=1"); end
    checks++; if (re_cnt - re0 != 16) begin failures++; $display("FAIL full_reads got=%0d exp=16", re_cnt - re0); end
    checks++; if (rx_data.size() - base != 16) begin failures++; $display("FAIL full_beats got=%0d exp=16", rx_data.size() - base); end
    if (rx_data.size() - base == 16) begin
      errs = 0;
      for (int i = 0; i < 16; i++)
        if (rx_data[base+i] !== 8'h60 + 8'(i) || rx_last[base+i] !== (i == 15)) errs++;
      checks++; if (errs != 0) begin failures++; $display("FAIL full_data_last got_errs=%0d exp=0", errs); end
      checks++; if (rx_cyc[base+15] - rx_cyc[base] != 15) begin failures++; $display("FAIL full_throughput got_span=%0d exp=15", rx_cyc[base+15] - rx_cyc[base]); end
    end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL full_fifo_empty got=%b exp=1", fifo_empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_ignored();
    test_reset_mid();
    test_full16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
